// File: rtl/branch_target_unit_pkg.sv
// Shared pipeline definitions for the branch target unit: default PC width,
// 2-bit predictor counter encodings and the saturating step function.
package branch_target_unit_pkg;

  localparam int DEFAULT_PC_W = 9;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  function automatic ctr_e sat_step(input ctr_e cur, input logic taken);
    if (taken) return (cur == ST)  ? ST  : ctr_e'(cur + 2'd1);
    else       return (cur == SNT) ? SNT : ctr_e'(cur - 2'd1);
  endfunction

endpackage

// File: rtl/branch_target_unit_if.sv
// Decode-stage operand/target bundle of the branch target unit.
// Predictor signals exist only when BTU_PREDICT_EN is defined.
interface branch_target_unit_if
  import branch_target_unit_pkg::*;
#(
  parameter int PC_W  = DEFAULT_PC_W,
  parameter int IMM_W = 9
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [PC_W-1:0]  pc_plus4;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic [PC_W-1:0]  pc_branch;
  logic             wrap;
`ifdef BTU_PREDICT_EN
  logic             resolve_valid;
  logic [PC_W-1:0]  resolve_pc;
  logic             resolve_taken;
  logic             predict_taken;
`endif

  modport master (
    output in_valid, stall, flush, pc_plus4, imm,
    input  out_valid, pc_branch, wrap
`ifdef BTU_PREDICT_EN
    , output resolve_valid, resolve_pc, resolve_taken
    , input  predict_taken
`endif
  );

  modport slave (
    input  in_valid, stall, flush, pc_plus4, imm,
    output out_valid, pc_branch, wrap
`ifdef BTU_PREDICT_EN
    , input  resolve_valid, resolve_pc, resolve_taken
    , output predict_taken
`endif
  );

endinterface

// File: rtl/branch_target_unit_sat_counter2.sv
// One 2-bit saturating branch predictor entry; resets to weakly not-taken.
module sat_counter2
  import branch_target_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic upd,
  input  logic taken,
  output ctr_e cnt
);
  ctr_e cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (upd) cnt_d = sat_step(cnt_q, taken);
  end

  // NOTE: every predictor entry carries its own reset, so this table is built
  // from flops and cannot be mapped onto a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= WNT;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_target_unit.sv
// Registered branch target adder (pc_plus4 + sext(imm) << SHIFT) with wrap flag.
// Optional BTU_PREDICT_EN adds a table of 2-bit saturating direction counters.
module branch_target_unit
  import branch_target_unit_pkg::*;
#(
  parameter int PC_W       = DEFAULT_PC_W,
  parameter int IMM_W      = 9,
  parameter int SHIFT      = 0,
  parameter int PRED_DEPTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  branch_target_unit_if.slave  bus
);
  // Three guard bits cover pc (< 2^PC_W) plus an offset of magnitude < 2^(PC_W+1).
  localparam int SUM_W = PC_W + 3;

  if (IMM_W < 1 || IMM_W > PC_W || SHIFT < 0 || SHIFT > 2 ||
      PRED_DEPTH < 2 || (PRED_DEPTH & (PRED_DEPTH - 1)) != 0) begin : g_bad_param
    $error("branch_target_unit: illegal parameter combination");
  end

  logic [SUM_W-1:0] offset;
  logic [SUM_W-1:0] sum;
  logic [PC_W-1:0]  pc_branch_q, pc_branch_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q, wrap_d;

  assign offset = {{(SUM_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} << SHIFT;
  assign sum    = {3'b000, bus.pc_plus4} + offset;

`ifdef BTU_PREDICT_EN
  localparam int IDX_W = $clog2(PRED_DEPTH);

  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic [PRED_DEPTH-1:0] ctr_msb;
  logic                  predict_taken_q, predict_taken_d;

  assign rd_idx = bus.pc_plus4[IDX_W+1:2];
  assign wr_idx = bus.resolve_pc[IDX_W+1:2];

  // Counters are read before this edge's update lands, so a same-cycle
  // read of the entry being resolved sees the old value.
  for (genvar i = 0; i < PRED_DEPTH; i++) begin : g_ctr
    ctr_e cnt;
    sat_counter2 u_ctr (
      .clk   (clk),
      .reset (reset),
      .upd   (bus.resolve_valid && (wr_idx == IDX_W'(i))),
      .taken (bus.resolve_taken),
      .cnt   (cnt)
    );
    assign ctr_msb[i] = cnt[1];
  end
`endif

  // NOTE: every signal written here gets its hold value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    out_valid_d = out_valid_q;
    pc_branch_d = pc_branch_q;
    wrap_d      = wrap_q;
`ifdef BTU_PREDICT_EN
    predict_taken_d = predict_taken_q;
`endif
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (!bus.stall) begin
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        pc_branch_d = sum[PC_W-1:0];
        wrap_d      = |sum[SUM_W-1:PC_W];
`ifdef BTU_PREDICT_EN
        predict_taken_d = ctr_msb[rd_idx];
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      pc_branch_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_branch_q <= pc_branch_d;
      wrap_q      <= wrap_d;
    end
  end

`ifdef BTU_PREDICT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) predict_taken_q <= 1'b0;
    else       predict_taken_q <= predict_taken_d;
  end

  assign bus.predict_taken = predict_taken_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.pc_branch = pc_branch_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench for branch_target_unit (SHIFT=0 and SHIFT=2
// instances); predictor steps are included when BTU_PREDICT_EN is defined.
module tb_branch_target_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  branch_target_unit_if #(.PC_W(9), .IMM_W(9)) bus0 ();
  branch_target_unit_if #(.PC_W(9), .IMM_W(9)) bus2 ();

  branch_target_unit #(.PC_W(9), .IMM_W(9), .SHIFT(0), .PRED_DEPTH(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  branch_target_unit #(.PC_W(9), .IMM_W(9), .SHIFT(2), .PRED_DEPTH(16)) u_dut_s2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [8:0] pc, input logic [8:0] imm);
    bus0.in_valid = v;
    bus0.pc_plus4 = pc;
    bus0.imm      = imm;
  endtask

  task automatic set2(input logic v, input logic [8:0] pc, input logic [8:0] imm);
    bus2.in_valid = v;
    bus2.pc_plus4 = pc;
    bus2.imm      = imm;
  endtask

  task automatic expect0(input string tag, input logic v, input logic [8:0] pc, input logic w);
    check({tag, ".valid"}, 32'(bus0.out_valid), 32'(v));
    check({tag, ".pc"},    32'(bus0.pc_branch), 32'(pc));
    check({tag, ".wrap"},  32'(bus0.wrap),      32'(w));
  endtask

`ifdef BTU_PREDICT_EN
  task automatic resolve(input logic v, input logic [8:0] pc, input logic taken);
    bus0.resolve_valid = v;
    bus0.resolve_pc    = pc;
    bus0.resolve_taken = taken;
  endtask
`endif

  initial begin
    set0(1'b0, 9'd0, 9'd0);
    set2(1'b0, 9'd0, 9'd0);
    bus0.stall = 1'b0; bus0.flush = 1'b0;
    bus2.stall = 1'b0; bus2.flush = 1'b0;
`ifdef BTU_PREDICT_EN
    resolve(1'b0, 9'd0, 1'b0);
    bus2.resolve_valid = 1'b0; bus2.resolve_pc = '0; bus2.resolve_taken = 1'b0;
`endif

    // Reset state, held across an edge
    #12;
    expect0("reset", 1'b0, 9'd0, 1'b0);
`ifdef BTU_PREDICT_EN
    check("reset.pred", 32'(bus0.predict_taken), 32'd0);
`endif
    tick();
    reset = 1'b0;

    // Basic targets; SHIFT=2 instance gets its own vectors
    set0(1'b1, 9'd8, 9'd4);   set2(1'b1, 9'd8, 9'd4);
    tick();
    expect0("add", 1'b1, 9'd12, 1'b0);
    check("s2_add.pc", 32'(bus2.pc_branch), 32'd24);
    check("s2_add.wrap", 32'(bus2.wrap), 32'd0);

    set0(1'b1, 9'd4, 9'h1F8); set2(1'b1, 9'd500, 9'd10);
    tick();
    expect0("neg", 1'b1, 9'd508, 1'b1);
    check("s2_poswrap.pc", 32'(bus2.pc_branch), 32'd28);
    check("s2_poswrap.wrap", 32'(bus2.wrap), 32'd1);

    // in_valid low clears valid but holds target/wrap
    set0(1'b0, 9'd100, 9'd1); set2(1'b1, 9'd0, 9'h1FF);
    tick();
    expect0("idle", 1'b0, 9'd508, 1'b1);
    check("s2_neg.pc", 32'(bus2.pc_branch), 32'd508);
    check("s2_neg.wrap", 32'(bus2.wrap), 32'd1);

    // Range boundaries
    set0(1'b1, 9'd511, 9'd1);    tick(); expect0("top_wrap", 1'b1, 9'd0,   1'b1);
    set0(1'b1, 9'd256, 9'd255);  tick(); expect0("max_pos",  1'b1, 9'd511, 1'b0);
    set0(1'b1, 9'd256, 9'h100);  tick(); expect0("max_neg",  1'b1, 9'd0,   1'b0);
    set0(1'b1, 9'd0,   9'h1FF);  tick(); expect0("under",    1'b1, 9'd511, 1'b1);

    // Stall holds everything for 3 cycles while inputs change
    set0(1'b1, 9'd100, 9'd20);   tick(); expect0("pre_stall", 1'b1, 9'd120, 1'b0);
    bus0.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set0(1'b1, 9'(200 + 7 * k), 9'(9'h1F0 + k));
      tick();
      expect0("stall", 1'b1, 9'd120, 1'b0);
    end
    set0(1'b0, 9'd3, 9'd3);      tick(); expect0("stall_idle", 1'b1, 9'd120, 1'b0);

    // Flush beats in_valid; flush beats stall
    bus0.stall = 1'b0; bus0.flush = 1'b1;
    set0(1'b1, 9'd300, 9'd5);    tick(); expect0("flush", 1'b0, 9'd120, 1'b0);
    bus0.flush = 1'b0;
    set0(1'b1, 9'd300, 9'd5);    tick(); expect0("post_flush", 1'b1, 9'd305, 1'b0);
    bus0.flush = 1'b1; bus0.stall = 1'b1;
    set0(1'b1, 9'd8, 9'd4);      tick(); expect0("flush_stall", 1'b0, 9'd305, 1'b0);
    bus0.flush = 1'b0; bus0.stall = 1'b0;

    // Asynchronous reset pulse between edges
    set0(1'b1, 9'd4, 9'h1F8);    tick(); expect0("pre_rst", 1'b1, 9'd508, 1'b1);
    #3 reset = 1'b1;
    #1;
    expect0("async_rst", 1'b0, 9'd0, 1'b0);
    check("async_rst.s2_pc", 32'(bus2.pc_branch), 32'd0);
    #2 reset = 1'b0;
    set0(1'b1, 9'd8, 9'd4);      tick(); expect0("post_rst", 1'b1, 9'd12, 1'b0);

`ifdef BTU_PREDICT_EN
    // Predictor: entry 4 (pc 0x10) starts weakly not-taken
    set0(1'b1, 9'h10, 9'd0);     tick();
    check("pred_init", 32'(bus0.predict_taken), 32'd0);
    set0(1'b0, 9'h10, 9'd0);
    resolve(1'b1, 9'h10, 1'b1);  tick(); tick();
    resolve(1'b0, 9'h10, 1'b0);
    set0(1'b1, 9'h10, 9'd0);     tick();
    check("pred_taken2", 32'(bus0.predict_taken), 32'd1);

    set0(1'b0, 9'h10, 9'd0);
    resolve(1'b1, 9'h10, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    resolve(1'b0, 9'h10, 1'b0);
    set0(1'b1, 9'h10, 9'd0);     tick();
    check("pred_nt4", 32'(bus0.predict_taken), 32'd0);

    // Counter sits at 0; one taken -> 1, then read alongside a taken update
    // must see 1 (MSB 0), and the following read sees 2 (MSB 1)
    set0(1'b0, 9'h10, 9'd0);
    resolve(1'b1, 9'h10, 1'b1);  tick();
    set0(1'b1, 9'h10, 9'd0);     tick();
    check("pred_bypass", 32'(bus0.predict_taken), 32'd0);
    resolve(1'b0, 9'h10, 1'b0);  tick();
    check("pred_after", 32'(bus0.predict_taken), 32'd1);

    // Resolve during flush still updates (2 -> 1); predict_taken holds
    bus0.flush = 1'b1;
    resolve(1'b1, 9'h10, 1'b0);  tick();
    check("flush_pred_hold", 32'(bus0.predict_taken), 32'd1);
    check("flush_pred_valid", 32'(bus0.out_valid), 32'd0);
    bus0.flush = 1'b0;
    resolve(1'b0, 9'h10, 1'b0);  tick();
    check("pred_flush_upd", 32'(bus0.predict_taken), 32'd0);

    #3 reset = 1'b1;
    #1;
    check("rst_pred", 32'(bus0.predict_taken), 32'd0);
    #2 reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
